stream_decipher: RTL and testbench
==================================

// Module: stream_decipher
// PURPOSE
//  Receive side of the byte-wise counter-mode stream cipher. Decrypts one ciphertext byte per accepted
//  beat: plaintext = din ^ sbox(cb). The counter cb is seeded by the key and advances by 1 mod 256 per byte.
//  Unlike the transmit side, both ports use valid/ready handshakes, with an internal FIFO for backpressure.
//  Sits between the link/receive interface and the plaintext consumer.
// PARAMETERS
//  FIFO_DEPTH  2  plaintext buffer entries; power of two, >= 2
// PORTS
//  clk         in   1  single clock, rising edge
//  rst_n       in   1  asynchronous active-low reset
//  key         in   8  key; sampled when key_in = 1
//  key_in      in   1  load key: reseed counter, flush buffer
//  din         in   8  ciphertext byte
//  din_valid   in   1  din holds a byte
//  din_ready   out  1  block accepts din this cycle
//  dout        out  8  plaintext byte (FIFO head); don't-care unless dout_valid = 1
//  dout_valid  out  1  dout holds a byte
//  dout_ready  in   1  consumer takes dout this cycle
//  keyed       out  1  a key has been loaded since reset
// BEHAVIOUR
//  - Reset (async assert, sync release): state = NOKEY, cb = 8'h00, FIFO empty.
//    Outputs: din_ready = 0, dout_valid = 0, keyed = 0. FIFO storage and dout are not reset.
//  - FSM NOKEY -> KEYED on key_in. KEYED has no exit except reset.
//    In NOKEY: din_ready = 0 and din is ignored.
//  - key_in has priority over all other inputs in the cycle it is high:
//    cb <= key; FIFO flushed (count <= 0); keyed <= 1.
//    No push and no pop that cycle; din_ready = 0 combinationally while key_in = 1.
//    A byte offered with dout_valid & dout_ready in that cycle is discarded, not delivered.
//  - Accept: push = din_valid & din_ready. On push, FIFO[wr] <= din ^ sbox(cb) and cb <= cb + 1
//    (8-bit, 8'hFF wraps to 8'h00).
//  - Deliver: pop = dout_valid & dout_ready; the head advances on pop.
//  - din_ready = keyed & ~key_in & (count < FIFO_DEPTH | dout_ready).
//    Full and popping in the same cycle still accepts. This is the only combinational in->out path.
//  - dout_valid = (count != 0). dout = FIFO[rd] is driven from registered storage.
//  - Latency: a byte pushed at edge N is on dout with dout_valid = 1 after edge N, if the FIFO was empty.
//  - Sustained throughput: 1 byte/cycle when dout_ready = 1.
//  - Simultaneous push & pop: count is unchanged, both pointers advance.
//    Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
//  - Empty with dout_ready = 1: no pop, no underflow.
//    Full with dout_ready = 0: din_ready = 0, din is held by the sender.
//  - Ordering: plaintext leaves in acceptance order; no byte is dropped except by a key_in flush.
//  - Keystream equivalence: after the same key, the k-th accepted byte uses cb = key + k (mod 256),
//    exactly matching the transmit side. decrypt(encrypt(x)) = x.
// STRUCTURE
//  - Shared package stream_cipher_pkg:
//      typedef logic [7:0] byte_t;
//      typedef enum logic {NOKEY, KEYED} dec_state_t;
//      localparam byte_t CB_STEP = 8'h01.
//  - Reuse the existing combinational sbox module for the keystream, one instance (in = cb).
//  - One natural sub-module: stream_fifo (DEPTH, 8-bit; push/pop/flush; full/empty/count).
//    Reusable for the transmit side later.
//  - The top level holds the FSM, cb, handshake logic, and the XOR.
// TESTING
//  Reference model: p = c ^ sbox(key + k). Scoreboard checks order and exact count.
//  1 Reset with din_valid = 1 and no key -> din_ready = 0, dout_valid = 0, keyed = 0 for 20 cycles.
//  2 key = 8'h3C, stream 16 bytes, dout_ready = 1 -> 16 outputs, 1/cycle, 1-cycle latency,
//    each = c ^ sbox(3C + k).
//  3 key = 8'hFE, 4 bytes -> cb sequence FE, FF, 00, 01 (wrap); outputs match the model.
//  4 dout_ready = 0 while sending 5 bytes, FIFO_DEPTH = 2 -> din_ready = 0 after 2 pushes;
//    release -> all 5 bytes in order, none lost or duplicated.
//  5 FIFO holding 2 bytes, then key_in with key = 8'h10 and din_valid = 1 ->
//    next cycle dout_valid = 0, the din byte is not accepted, and the next byte decrypts with cb = 8'h10.
//  6 Loopback: stream_cipher -> stream_decipher, same key 8'hA5, 300 random bytes,
//    random dout_ready -> output == input; async reset mid-stream -> outputs at reset values immediately.

Source files
------------

// File: rtl/stream_cipher_pkg.sv
// Shared types and constants for the byte-wise counter-mode stream cipher
// (transmit and receive sides).
//   byte_t      : 8-bit data byte
//   dec_state_t : receive-side FSM state
//   CB_STEP     : counter increment per processed byte
package stream_cipher_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic {
    NOKEY = 1'b0,
    KEYED = 1'b1
  } dec_state_t;

  localparam byte_t CB_STEP = 8'h01;

endpackage

// File: rtl/sbox.sv
// Combinational keystream substitution box. Bijective on 8 bits:
// y = (7 * x mod 256) ^ 8'h5A. Multiplication by an odd constant is a
// permutation of the byte values, so every counter value maps to a unique
// keystream byte.
// Ports:
//   x  in   8  counter value
//   y  out  8  keystream byte
module sbox
  import stream_cipher_pkg::*;
(
  input  logic [7:0] x,
  output logic [7:0] y
);

  // 7*x built from shifts: 4x + 2x + x, truncated to 8 bits.
  byte_t times7;
  assign times7 = {x[5:0], 2'b00} + {x[6:0], 1'b0} + x;
  assign y      = times7 ^ 8'h5A;

endmodule

// File: rtl/stream_fifo.sv
// Small synchronous FIFO with flush. Storage is not reset; only the
// pointers and occupancy are. Flush has priority over push and pop.
// Ports:
//   clk    in   1            clock, rising edge
//   rst_n  in   1            asynchronous active-low reset
//   push   in   1            write din at the tail (caller guarantees not full
//                            unless popping in the same cycle)
//   pop    in   1            advance the head (caller guarantees not empty)
//   flush  in   1            empty the FIFO
//   din    in   WIDTH        write data
//   dout   out  WIDTH        head entry (registered storage)
//   full   out  1            count == DEPTH
//   count  out  log2(D)+1    current occupancy
module stream_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Pointers are exactly log2(DEPTH) bits, so they wrap without compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];
  assign full = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/stream_decipher.sv
// Receive side of the byte-wise counter-mode stream cipher.
// Each accepted ciphertext byte is decrypted as din ^ sbox(cb) and buffered;
// cb is seeded by key and advances by one per accepted byte.
// Ports:
//   clk         in   1  clock, rising edge
//   rst_n       in   1  asynchronous active-low reset
//   key         in   8  key, sampled when key_in = 1
//   key_in      in   1  load key: reseed counter, flush buffer
//   din         in   8  ciphertext byte
//   din_valid   in   1  din holds a byte
//   din_ready   out  1  block accepts din this cycle
//   dout        out  8  plaintext byte (buffer head)
//   dout_valid  out  1  dout holds a byte
//   dout_ready  in   1  consumer takes dout this cycle
//   keyed       out  1  a key has been loaded since reset
//
// State table:
//   state | meaning
//   NOKEY | no key since reset; input side stalled, din ignored
//   KEYED | key loaded; decrypting and buffering (exit only by reset)
module stream_decipher
  import stream_cipher_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] key,
  input  logic       key_in,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       keyed
);

  dec_state_t               state;
  byte_t                    cb;
  byte_t                    keystream;
  byte_t                    plain;
  logic                     push;
  logic                     pop;
  logic                     fifo_full;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= NOKEY;
      cb    <= 8'h00;
    end else if (key_in) begin
      state <= KEYED;
      cb    <= key;
    end else if (push) begin
      cb    <= cb + CB_STEP;
    end
  end

  assign keyed = (state == KEYED);

  // A full buffer that is draining this cycle can still take a byte.
  assign din_ready  = keyed & ~key_in & (~fifo_full | dout_ready);
  assign dout_valid = (fifo_count != '0);

  assign push = din_valid & din_ready;
  // A head offered during a key load is flushed, not delivered.
  assign pop  = dout_valid & dout_ready & ~key_in;

  sbox u_sbox (
    .x (cb),
    .y (keystream)
  );

  assign plain = din ^ keystream;

  stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (key_in),
    .din   (plain),
    .dout  (dout),
    .full  (fifo_full),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_stream_decipher.sv
module tb_stream_decipher;
  import stream_cipher_pkg::*;

  localparam int DEPTH = 2;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  byte_t key = 8'h00;
  logic  key_in = 1'b0;
  byte_t din = 8'h00;
  logic  din_valid = 1'b0;
  logic  din_ready;
  byte_t dout;
  logic  dout_valid;
  logic  dout_ready = 1'b0;
  logic  keyed;

  int    n_checks = 0;
  int    n_err = 0;

  byte_t exp_q[$];
  byte_t got_q[$];
  logic  m_keyed = 1'b0;
  byte_t m_cb = 8'h00;

  stream_decipher #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key        (key),
    .key_in     (key_in),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .keyed      (keyed)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic byte_t ref_sbox(input byte_t b);
    byte_t m;
    m = b * 8'd7;
    return m ^ 8'h5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check outputs against the model,
  // then advance the model as the coming rising edge will.
  task automatic step(input logic kin, input byte_t k, input logic dv, input byte_t d,
                      input logic dr, output logic acc);
    logic exp_rdy;
    logic exp_v;
    @(negedge clk);
    key_in = kin; key = k; din_valid = dv; din = d; dout_ready = dr;
    #1;
    exp_v   = (exp_q.size() != 0);
    exp_rdy = m_keyed & ~kin & ((exp_q.size() < DEPTH) | dr);
    chk("keyed", keyed, m_keyed);
    chk("din_ready", din_ready, exp_rdy);
    chk("dout_valid", dout_valid, exp_v);
    if (exp_v) chk("dout", dout, exp_q[0]);
    acc = 1'b0;
    if (kin) begin
      m_cb = k;
      exp_q.delete();
      m_keyed = 1'b1;
    end else begin
      if (exp_v && dr) begin
        got_q.push_back(dout);
        void'(exp_q.pop_front());
      end
      if (dv && exp_rdy) begin
        exp_q.push_back(d ^ ref_sbox(m_cb));
        m_cb = m_cb + 8'h01;
        acc = 1'b1;
      end
    end
  endtask

  initial begin
    logic  acc;
    int    idx;
    int    cyc;
    byte_t src4 [5];
    byte_t src6 [300];
    byte_t tx_cb;
    byte_t c;
    logic  dv;

    // 1: reset, no key, din offered
    din_valid = 1'b1; din = 8'h77;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_din_ready", din_ready, 1'b0);
    chk("rst_dout_valid", dout_valid, 1'b0);
    chk("rst_keyed", keyed, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1, 8'h77, 1'b1, acc);

    // 2: key 3C, 16 bytes back to back
    step(1'b1, 8'h3C, 1'b0, 8'h00, 1'b1, acc);
    got_q.delete();
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1, byte_t'(i * 17), 1'b1, acc);
      chk("t2_accept", acc, 1'b1);
    end
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, acc);
    chk("t2_count", got_q.size(), 16);
    chk("t2_first", got_q[0], 8'hFE);

    // 3: key FE, counter wraps FE FF 00 01
    step(1'b1, 8'hFE, 1'b0, 8'h00, 1'b1, acc);
    got_q.delete();
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 8'h00, 1'b1, acc);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, acc);
    chk("t3_count", got_q.size(), 4);
    chk("t3_cb_fe", got_q[0], 8'hA8);
    chk("t3_cb_ff", got_q[1], 8'hA3);
    chk("t3_cb_00", got_q[2], 8'h5A);
    chk("t3_cb_01", got_q[3], 8'h5D);

    // 4: backpressure with 5 bytes
    step(1'b1, 8'h20, 1'b0, 8'h00, 1'b0, acc);
    got_q.delete();
    for (int i = 0; i < 5; i++) src4[i] = 8'hA0 + byte_t'(i);
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 8'h00, 1'b1, src4[idx], 1'b0, acc);
      if (acc) idx++;
    end
    chk("t4_held", idx, 2);
    chk("t4_full_stall", din_ready, 1'b0);
    cyc = 0;
    while (got_q.size() < 5 && cyc < 40) begin
      dv = (idx < 5);
      step(1'b0, 8'h00, dv, dv ? src4[idx] : 8'h00, 1'b1, acc);
      if (acc) idx++;
      cyc++;
    end
    chk("t4_count", got_q.size(), 5);
    chk("t4_first", got_q[0], 8'h1A);
    for (int i = 0; i < 5; i++)
      if (i < got_q.size()) chk("t4_order", got_q[i], src4[i] ^ ref_sbox(8'h20 + byte_t'(i)));

    // 5: key load over a full buffer with din offered
    step(1'b0, 8'h00, 1'b1, 8'h11, 1'b0, acc);
    step(1'b0, 8'h00, 1'b1, 8'h22, 1'b0, acc);
    chk("t5_prefull", dout_valid, 1'b1);
    got_q.delete();
    step(1'b1, 8'h10, 1'b1, 8'h99, 1'b1, acc);
    chk("t5_key_stall", din_ready, 1'b0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, acc);
    chk("t5_flushed", dout_valid, 1'b0);
    step(1'b0, 8'h00, 1'b1, 8'h00, 1'b1, acc);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, acc);
    chk("t5_count", got_q.size(), 1);
    chk("t5_cb10", got_q[0], 8'h2A);

    // 6: loopback against a transmit-side encryptor, random flow control
    step(1'b1, 8'hA5, 1'b0, 8'h00, 1'b1, acc);
    got_q.delete();
    for (int i = 0; i < 300; i++) src6[i] = byte_t'($urandom_range(0, 255));
    tx_cb = 8'hA5;
    idx = 0;
    cyc = 0;
    while ((idx < 300 || exp_q.size() != 0) && cyc < 4000) begin
      dv = (idx < 300) && ($urandom_range(0, 3) != 0);
      c  = (idx < 300) ? (src6[idx] ^ ref_sbox(tx_cb)) : 8'h00;
      step(1'b0, 8'h00, dv, c, 1'($urandom_range(0, 1)), acc);
      if (acc) begin
        idx++;
        tx_cb = tx_cb + 8'h01;
      end
      cyc++;
    end
    chk("t6_count", got_q.size(), 300);
    for (int i = 0; i < 300; i++)
      if (i < got_q.size()) chk("t6_data", got_q[i], src6[i]);

    // 6b: asynchronous reset with a full buffer
    step(1'b0, 8'h00, 1'b1, 8'h01, 1'b0, acc);
    step(1'b0, 8'h00, 1'b1, 8'h02, 1'b0, acc);
    @(negedge clk);
    din_valid = 1'b1;
    dout_ready = 1'b0;
    #1;
    chk("t6_prereset_valid", dout_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_arst_din_ready", din_ready, 1'b0);
    chk("t6_arst_dout_valid", dout_valid, 1'b0);
    chk("t6_arst_keyed", keyed, 1'b0);
    m_keyed = 1'b0;
    m_cb = 8'h00;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 8'h55, 1'b1, acc);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
